// File: rtl/digital_pll_controller_lockdet.sv
// Trim controller for the ring-oscillator digital PLL: measures each osc period in clock cycles,
// steers a saturating fractional trim accumulator toward div, and reports lock and lost reference.
module digital_pll_controller_lockdet #(
  parameter int DIV_W      = 5,
  parameter int CNT_W      = 5,
  parameter int TRIM_W     = 26,
  parameter int FRAC_W     = 2,
  parameter int COARSE_THR = 4,
  parameter int LOCK_TOL   = 0,
  parameter int UNLOCK_TOL = 1,
  parameter int LOCK_CNT   = 8,
  parameter int RESET_TINT = 0,
  localparam int TI_W      = $clog2(TRIM_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              osc,
  input  logic              enable,
  input  logic              hold,
  input  logic [DIV_W-1:0]  div,
  output logic [TRIM_W-1:0] trim,
  output logic [TI_W-1:0]   tint,
  output logic              locked,
  output logic              osc_lost
);

  localparam int TV_W = TI_W + FRAC_W;
  localparam int EW   = ((CNT_W + 1) > DIV_W ? (CNT_W + 1) : DIV_W) + 1;
  localparam logic [TV_W-1:0]  TV_MAX  = TV_W'(TRIM_W * (2 ** FRAC_W) + (2 ** FRAC_W) - 1);
  localparam logic [TV_W-1:0]  TV_RST  = TV_W'(RESET_TINT * (2 ** FRAC_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {IDLE, PREP, TRACK, LOCK} state_t;

  state_t            state, state_next;
  logic [2:0]        oscbuf;
  logic [CNT_W-1:0]  count0, count0_next;
  logic [CNT_W-1:0]  count1, count1_next;
  logic [1:0]        prepcnt, prepcnt_next;
  logic [7:0]        lockcnt, lockcnt_next;
  logic [TV_W-1:0]   tval, tval_next, tval_adj;
  logic              locked_next, osc_lost_next;

  logic              osc_edge, lost_evt, count_lock;
  logic [CNT_W:0]    sum;
  logic signed [EW-1:0] err;
  logic [EW-1:0]     abs_err;
  logic              coarse, in_lock, out_lock, err_pos, err_neg;
  logic [TV_W-1:0]   step;
  logic [TV_W:0]     tval_up;
  logic [TI_W-1:0]   tint_raw;

  assign osc_edge = oscbuf[2] ^ oscbuf[1];
  assign sum      = {1'b0, count0} + {1'b0, count1};
  assign err      = $signed({{(EW-CNT_W-1){1'b0}}, sum}) - $signed({{(EW-DIV_W){1'b0}}, div});
  assign abs_err  = err[EW-1] ? EW'(-err) : EW'(err);
  assign err_neg  = err[EW-1];
  assign err_pos  = !err[EW-1] && (err != '0);
  assign coarse   = abs_err >= EW'(COARSE_THR);
  assign in_lock  = abs_err <= EW'(LOCK_TOL);
  assign out_lock = abs_err > EW'(UNLOCK_TOL);
  // Lost reference fires once, on the cycle count0 steps into saturation.
  assign lost_evt = (state != IDLE) && !osc_edge && (count0 == CNT_PRE);

  always_comb begin
    step    = coarse ? TV_W'(2 ** FRAC_W) : TV_W'(1);
    tval_up = {1'b0, tval} + {1'b0, step};
    tval_adj = tval;
    if (err_pos) begin
      tval_adj = (tval_up > {1'b0, TV_MAX}) ? TV_MAX : tval_up[TV_W-1:0];
    end else if (err_neg) begin
      tval_adj = (tval < step) ? '0 : tval - step;
    end
  end

  always_comb begin
    state_next    = state;
    count0_next   = osc_edge ? CNT_W'(1) : ((count0 == CNT_MAX) ? count0 : count0 + 1'b1);
    count1_next   = osc_edge ? count0 : count1;
    prepcnt_next  = prepcnt;
    lockcnt_next  = lockcnt;
    tval_next     = tval;
    locked_next   = locked;
    osc_lost_next = osc_edge ? 1'b0 : osc_lost;
    count_lock    = 1'b0;
    if (!enable || state == IDLE) begin
      count0_next  = '0;
      count1_next  = '0;
      prepcnt_next = '0;
      lockcnt_next = '0;
      locked_next  = 1'b0;
      state_next   = enable ? PREP : IDLE;
    end else if (lost_evt) begin
      osc_lost_next = 1'b1;
      locked_next   = 1'b0;
      prepcnt_next  = '0;
      lockcnt_next  = '0;
      state_next    = PREP;
    end else if (osc_edge) begin
      case (state)
        PREP: begin
          if (prepcnt == 2'd2) begin
            state_next = TRACK;
            count_lock = 1'b1;
            if (!hold) tval_next = tval_adj;
          end else begin
            prepcnt_next = prepcnt + 2'd1;
          end
        end
        TRACK: begin
          count_lock = 1'b1;
          if (!hold) tval_next = tval_adj;
        end
        LOCK: begin
          if (!hold) tval_next = tval_adj;
          if (out_lock) begin
            state_next   = TRACK;
            lockcnt_next = '0;
            locked_next  = 1'b0;
          end
        end
        default: ;
      endcase
      if (count_lock) begin
        lockcnt_next = in_lock ? lockcnt + 8'd1 : '0;
        if (in_lock && ({1'b0, lockcnt} + 9'd1 >= 9'(LOCK_CNT))) begin
          state_next  = LOCK;
          locked_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      oscbuf   <= '0;
      count0   <= '0;
      count1   <= '0;
      prepcnt  <= '0;
      lockcnt  <= '0;
      tval     <= TV_RST;
      locked   <= 1'b0;
      osc_lost <= 1'b0;
    end else begin
      state    <= state_next;
      oscbuf   <= {oscbuf[1:0], osc};
      count0   <= count0_next;
      count1   <= count1_next;
      prepcnt  <= prepcnt_next;
      lockcnt  <= lockcnt_next;
      tval     <= tval_next;
      locked   <= locked_next;
      osc_lost <= osc_lost_next;
    end
  end

  always_comb begin
    tint_raw = tval[TV_W-1:FRAC_W];
    tint     = (tint_raw > TI_W'(TRIM_W)) ? TI_W'(TRIM_W) : tint_raw;
    for (int unsigned i = 0; i < TRIM_W; i++) begin
      trim[i] = TI_W'(i) < tint;
    end
  end

endmodule

// File: tb/tb_digital_pll_controller_lockdet.sv
// Bench for digital_pll_controller_lockdet: directed vector table, hand sequences for lock,
// lost-reference and hold/enable, then random osc traffic checked against a timestamp-based model.
module tb_digital_pll_controller_lockdet;

  localparam int DIV_W = 5, CNT_W = 5, TRIM_W = 26, FRAC_W = 2;
  localparam int COARSE_THR = 4, LOCK_TOL = 0, UNLOCK_TOL = 1, LOCK_CNT = 8, RESET_TINT = 0;
  localparam int TI_W = 5;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int ONE  = 1 << FRAC_W;
  localparam int TVMAX = TRIM_W * ONE + ONE - 1;
  localparam int M_IDLE = 0, M_PREP = 1, M_TRACK = 2, M_LOCK = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              osc = 1'b0;
  logic              enable = 1'b0;
  logic              hold = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [TRIM_W-1:0] trim;
  logic [TI_W-1:0]   tint;
  logic              locked, osc_lost;

  int n_checks = 0;
  int n_fail = 0;

  digital_pll_controller_lockdet #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .TRIM_W(TRIM_W), .FRAC_W(FRAC_W),
    .COARSE_THR(COARSE_THR), .LOCK_TOL(LOCK_TOL), .UNLOCK_TOL(UNLOCK_TOL),
    .LOCK_CNT(LOCK_CNT), .RESET_TINT(RESET_TINT)
  ) dut (
    .clock(clock), .reset(reset), .osc(osc), .enable(enable), .hold(hold), .div(div),
    .trim(trim), .tint(tint), .locked(locked), .osc_lost(osc_lost)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: half-periods come from edge timestamps, the trim value is a plain integer.
  bit osc_hist[$];
  int n = 0;
  int m_mode, m_anchor, m_cnt1, m_prep, m_streak, m_tval, m_locked, m_lost;

  always @(posedge clock) begin
    int c0, err, aerr, stp, et;
    bit e;
    osc_hist.push_back(osc);
    e  = (n >= 3) && (osc_hist[n-2] != osc_hist[n-3]);
    c0 = n - m_anchor;
    if (c0 > CMAX) c0 = CMAX;
    if (reset) begin
      m_mode = M_IDLE; m_anchor = n + 1; m_cnt1 = 0; m_prep = 0; m_streak = 0;
      m_tval = RESET_TINT * ONE; m_locked = 0; m_lost = 0;
    end else if (!enable || m_mode == M_IDLE) begin
      if (e) m_lost = 0;
      m_anchor = n + 1; m_cnt1 = 0; m_prep = 0; m_streak = 0; m_locked = 0;
      m_mode = enable ? M_PREP : M_IDLE;
    end else if (c0 == CMAX - 1 && !e) begin
      m_lost = 1; m_locked = 0; m_prep = 0; m_streak = 0; m_mode = M_PREP;
    end else if (e) begin
      err  = c0 + m_cnt1 - int'(div);
      aerr = (err < 0) ? -err : err;
      m_lost = 0; m_cnt1 = c0; m_anchor = n;
      if (m_mode == M_PREP && m_prep < 2) begin
        m_prep++;
      end else begin
        if (!hold) begin
          stp = (aerr < COARSE_THR) ? 1 : ONE;
          if (err > 0) m_tval = (m_tval + stp > TVMAX) ? TVMAX : m_tval + stp;
          else if (err < 0) m_tval = (m_tval - stp < 0) ? 0 : m_tval - stp;
        end
        if (m_mode == M_LOCK) begin
          if (aerr > UNLOCK_TOL) begin m_mode = M_TRACK; m_streak = 0; m_locked = 0; end
        end else begin
          m_mode = M_TRACK;
          m_streak = (aerr <= LOCK_TOL) ? m_streak + 1 : 0;
          if (m_streak >= LOCK_CNT) begin m_mode = M_LOCK; m_locked = 1; end
        end
      end
    end
    n++;
    #1;
    et = m_tval / ONE;
    if (et > TRIM_W) et = TRIM_W;
    check("model_tint", 32'(tint), et);
    check("model_trim", 32'(trim), (1 << et) - 1);
    check("model_locked", 32'(locked), m_locked);
    check("model_osc_lost", 32'(osc_lost), m_lost);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; hold = 1'b0; osc = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic run_osc(input int h, input int edges);
    repeat (edges) begin
      osc = ~osc;
      tick(h);
    end
  endtask

  task automatic check_tint(input string name, input int exp);
    check(name, 32'(tint), exp);
    check({name, "_trim"}, 32'(trim), (1 << exp) - 1);
  endtask

  typedef struct {
    int div;
    int h;
    int edges;
    int tint;
    int locked;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{div: 8,  h: 6,  edges: 10, tint: 8,  locked: 0};
    tbl[1] = '{div: 12, h: 6,  edges: 10, tint: 0,  locked: 1};
    tbl[2] = '{div: 12, h: 6,  edges: 9,  tint: 0,  locked: 0};
    tbl[3] = '{div: 11, h: 6,  edges: 10, tint: 2,  locked: 0};
    tbl[4] = '{div: 16, h: 6,  edges: 12, tint: 0,  locked: 0};
    tbl[5] = '{div: 8,  h: 10, edges: 40, tint: 26, locked: 0};
    tbl[6] = '{div: 31, h: 3,  edges: 12, tint: 0,  locked: 0};
    tbl[7] = '{div: 13, h: 6,  edges: 6,  tint: 0,  locked: 0};
    tbl[8] = '{div: 9,  h: 6,  edges: 14, tint: 3,  locked: 0};
    tbl[9] = '{div: 20, h: 12, edges: 5,  tint: 3,  locked: 0};

    // Reset held: outputs stay at their reset values
    repeat (10) begin
      @(negedge clock);
      check("rst_tint", 32'(tint), 0);
      check("rst_trim", 32'(trim), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_osc_lost", 32'(osc_lost), 0);
    end
    reset = 1'b0;

    foreach (tbl[i]) begin
      do_reset();
      div = DIV_W'(tbl[i].div);
      enable = 1'b1;
      tick(2);
      run_osc(tbl[i].h, tbl[i].edges);
      check_tint($sformatf("tbl%0d_tint", i), tbl[i].tint);
      check($sformatf("tbl%0d_locked", i), 32'(locked), tbl[i].locked);
    end

    // Lock, unlock on div change, relock, lost reference, recovery through PREP
    do_reset();
    div = 5'd8; enable = 1'b1; tick(2);
    run_osc(6, 7);
    check_tint("seqa_start", 5);
    div = 5'd12;
    run_osc(6, 7);
    check("seqa_prelock", 32'(locked), 0);
    run_osc(6, 1);
    check("seqa_locked", 32'(locked), 1);
    check_tint("seqa_lock_tint", 5);
    div = 5'd15;
    run_osc(6, 1);
    check("seqa_unlock", 32'(locked), 0);
    check_tint("seqa_unlock_tint", 4);
    div = 5'd12;
    run_osc(6, 8);
    check("seqa_relock", 32'(locked), 1);
    tick(40);
    check("seqa_lost", 32'(osc_lost), 1);
    check("seqa_lost_locked", 32'(locked), 0);
    check_tint("seqa_lost_tint", 4);
    div = 5'd8;
    run_osc(6, 1);
    check("seqa_lost_clear", 32'(osc_lost), 0);
    check_tint("seqa_prep1", 4);
    run_osc(6, 1);
    check_tint("seqa_prep2", 4);
    run_osc(6, 1);
    check_tint("seqa_prep3", 5);

    // Hold freezes the trim while lock detection continues; enable low drops to idle
    do_reset();
    div = 5'd8; enable = 1'b1; tick(2);
    run_osc(6, 7);
    hold = 1'b1; div = 5'd16;
    run_osc(6, 6);
    check_tint("seqb_hold", 5);
    div = 5'd12;
    run_osc(6, 8);
    check("seqb_hold_locked", 32'(locked), 1);
    hold = 1'b0; enable = 1'b0;
    tick(1);
    check("seqb_idle_locked", 32'(locked), 0);
    check_tint("seqb_idle_tint", 5);
    enable = 1'b1; div = 5'd8;
    tick(2);
    run_osc(6, 2);
    check_tint("seqb_prep", 5);
    run_osc(6, 1);
    check_tint("seqb_first", 6);

    // Random traffic, checked every cycle by the model
    for (int s = 0; s < 150; s++) begin
      int base, edges;
      if ($urandom_range(0, 19) == 0) do_reset();
      enable = ($urandom_range(0, 9) != 0);
      hold   = ($urandom_range(0, 4) == 0);
      div    = DIV_W'($urandom_range(0, 31));
      base   = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 38) : $urandom_range(1, 14);
      edges  = $urandom_range(1, 10);
      for (int k = 0; k < edges; k++) begin
        int h;
        h = base + $urandom_range(0, 2) - 1;
        if (h < 1) h = 1;
        run_osc(h, 1);
      end
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
